alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 64-bit combinational ALU in the ARM64 pipeline.
- Registers result and flags, and adds an iterative multiply (MUL).
- Holds a persistent NZVC flag register, updated only by flag-setting ops (ADDS/SUBS-style).
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 107 ++++++++++
 tb/tb_alu_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq (request, operands, result, per-op flags, flag register, busy)
interface alu_seq_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic             flag_c;
  logic             busy;
  modport master (
    output in_valid, A, B, cntrl, set_flags, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry_out,
           flag_n, flag_z, flag_v, flag_c, busy
  );
  modport slave (
    input  in_valid, A, B, cntrl, set_flags, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry_out,
           flag_n, flag_z, flag_v, flag_c, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU with iterative shift-add MUL and persistent NZVC flags; ports clk, reset, io (alu_seq_if.slave)
module alu_seq #(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input logic   clk,
  input logic   reset,
  alu_seq_if.slave io
);
  localparam int ITER = WIDTH / MUL_STEP;
  localparam int CW   = $clog2(ITER + 1);
  localparam int M    = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ma_q, mb_q, acc_q, pp, mul_sum, res;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt_q;
  logic             sf_q, accept, done_hs, last, is_add, is_sub, is_mul, v, c;
  assign is_add  = io.cntrl == 3'b010;
  assign is_sub  = io.cntrl == 3'b011;
  assign is_mul  = io.cntrl == 3'b111;
  assign io.in_ready  = state_q == IDLE || (state_q == DONE && io.out_ready);
  assign io.out_valid = state_q == DONE;
  assign io.busy      = state_q == MUL;
  assign accept  = io.in_valid && io.in_ready;
  assign done_hs = state_q == DONE && io.out_ready;
  assign last    = cnt_q == CW'(1);
  // Subtract is A + ~B + 1, so the carry is the ARM-style not-borrow.
  always_comb begin
    sum = {1'b0, io.A} + {1'b0, is_sub ? ~io.B : io.B} + {{WIDTH{1'b0}}, is_sub};
    res = (is_add || is_sub) ? sum[M:0] :
          io.cntrl == 3'b100 ? io.A & io.B :
          io.cntrl == 3'b101 ? io.A | io.B :
          io.cntrl == 3'b110 ? io.A ^ io.B : io.B;
    v = is_add ? (io.A[M] == io.B[M]) && (sum[M] != io.A[M]) :
        is_sub ? (io.A[M] != io.B[M]) && (sum[M] != io.A[M]) : 1'b0;
    c = (is_add || is_sub) && sum[WIDTH];
  end
  // One shift-add step: multiplicand shifted by each of the low MUL_STEP multiplier bits.
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++)
      if (mb_q[i]) pp = pp + (ma_q << i);
    mul_sum = acc_q + pp;
  end
  always_comb begin
    state_d = accept ? (is_mul ? MUL : DONE) :
              (state_q == MUL && last) ? DONE :
              done_hs ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma_q         <= '0;
      mb_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      sf_q         <= 1'b0;
      io.result    <= '0;
      io.negative  <= 1'b0;
      io.zero      <= 1'b0;
      io.overflow  <= 1'b0;
      io.carry_out <= 1'b0;
      io.flag_n    <= 1'b0;
      io.flag_z    <= 1'b0;
      io.flag_v    <= 1'b0;
      io.flag_c    <= 1'b0;
    end else begin
      // Commit uses the outgoing op's flags even when a new op is accepted on the same edge.
      if (done_hs && sf_q) begin
        io.flag_n <= io.negative;
        io.flag_z <= io.zero;
        io.flag_v <= io.overflow;
        io.flag_c <= io.carry_out;
      end
      if (accept) begin
        sf_q <= io.set_flags;
        if (is_mul) begin
          ma_q  <= io.A;
          mb_q  <= io.B;
          acc_q <= '0;
          cnt_q <= CW'(ITER);
        end else begin
          io.result    <= res;
          io.negative  <= res[M];
          io.zero      <= res == '0;
          io.overflow  <= v;
          io.carry_out <= c;
        end
      end else if (state_q == MUL) begin
        ma_q  <= ma_q << MUL_STEP;
        mb_q  <= mb_q >> MUL_STEP;
        acc_q <= mul_sum;
        cnt_q <= cnt_q - CW'(1);
        if (last) begin
          io.result    <= mul_sum;
          io.negative  <= mul_sum[M];
          io.zero      <= mul_sum == '0;
          io.overflow  <= 1'b0;
          io.carry_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (64-bit/step-1 and 8-bit/step-4 instances)
module tb_alu_seq;
  logic clk, reset;
  int checks = 0;
  int errors = 0;
  int cnt;
  alu_seq_if #(.WIDTH(64)) b0 ();
  alu_seq_if #(.WIDTH(8))  b1 ();
  alu_seq #(.WIDTH(64), .MUL_STEP(1)) d0 (.clk(clk), .reset(reset), .io(b0.slave));
  alu_seq #(.WIDTH(8),  .MUL_STEP(4)) d1 (.clk(clk), .reset(reset), .io(b1.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] nzvc();
    return {b0.negative, b0.zero, b0.overflow, b0.carry_out};
  endfunction
  function automatic logic [3:0] flags();
    return {b0.flag_n, b0.flag_z, b0.flag_v, b0.flag_c};
  endfunction
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input logic sf);
    @(negedge clk);
    b0.A = a; b0.B = b; b0.cntrl = op; b0.set_flags = sf; b0.in_valid = 1'b1;
    @(posedge clk);
    #1 b0.in_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic drain();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    b0.in_valid = 0; b0.A = '0; b0.B = '0; b0.cntrl = '0; b0.set_flags = 0; b0.out_ready = 1;
    b1.in_valid = 0; b1.A = '0; b1.B = '0; b1.cntrl = '0; b1.set_flags = 0; b1.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_result", b0.result, 0);
    chk("rst_nzvc", nzvc(), 0);
    chk("rst_flags", flags(), 0);
    chk("rst_busy", b0.busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", b0.in_ready, 1);
    send(64'd1, 64'd1, 3'b010, 1);
    chk("add1_valid", b0.out_valid, 1);
    chk("add1_result", b0.result, 64'd2);
    chk("add1_nzvc", nzvc(), 4'b0000);
    drain();
    chk("add1_flags", flags(), 4'b0000);
    chk("add1_idle", b0.out_valid, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1);
    chk("addv_result", b0.result, 64'h8000_0000_0000_0000);
    chk("addv_nzvc", nzvc(), 4'b1010);
    drain();
    chk("addv_flags", flags(), 4'b1010);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 0);
    chk("addc_result", b0.result, 64'd0);
    chk("addc_nzvc", nzvc(), 4'b0101);
    drain();
    chk("addc_flags_kept", flags(), 4'b1010);
    send(64'd2, 64'd5, 3'b011, 0);
    chk("sub25_result", b0.result, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("sub25_nzvc", nzvc(), 4'b1000);
    drain();
    send(64'd5, 64'd2, 3'b011, 0);
    chk("sub52_result", b0.result, 64'd3);
    chk("sub52_nzvc", nzvc(), 4'b0001);
    drain();
    send(64'h8000_0000_0000_0000, 64'd1, 3'b011, 0);
    chk("subv_result", b0.result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("subv_nzvc", nzvc(), 4'b0011);
    drain();
    send(64'd1, 64'h1234, 3'b001, 0);
    chk("rsvd_result", b0.result, 64'h1234);
    chk("rsvd_nzvc", nzvc(), 4'b0000);
    drain();
    send(64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 0);
    chk("pass_result", b0.result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pass_nzvc", nzvc(), 4'b1000);
    drain();
    send(64'd5, 64'd5, 3'b011, 1);
    chk("subs55_nzvc", nzvc(), 4'b0101);
    drain();
    chk("subs55_flags", flags(), 4'b0101);
    send(64'hF0, 64'h0F, 3'b100, 0);
    chk("and_result", b0.result, 64'd0);
    chk("and_nzvc", nzvc(), 4'b0100);
    drain();
    chk("and_flags_kept", flags(), 4'b0101);
    send(64'hF0, 64'hF0, 3'b110, 1);
    chk("xor_nzvc", nzvc(), 4'b0100);
    drain();
    chk("xor_flags", flags(), 4'b0100);
    @(negedge clk);
    b0.A = 64'd3; b0.B = 64'd4; b0.cntrl = 3'b010; b0.set_flags = 0; b0.in_valid = 1;
    @(posedge clk);
    #1 b0.A = 64'h10; b0.B = 64'h01; b0.cntrl = 3'b101;
    @(negedge clk);
    chk("b2b_first", b0.result, 64'd7);
    chk("b2b_in_ready", b0.in_ready, 1);
    @(posedge clk);
    #1 b0.in_valid = 0;
    @(negedge clk);
    chk("b2b_second", b0.result, 64'h11);
    chk("b2b_valid", b0.out_valid, 1);
    drain();
    b0.out_ready = 0;
    @(negedge clk);
    b0.A = 64'h1_0000_0001; b0.B = 64'd3; b0.cntrl = 3'b111; b0.set_flags = 1; b0.in_valid = 1;
    @(posedge clk);
    #1 b0.in_valid = 0; b0.A = '0; b0.B = '0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (b0.busy && !b0.in_ready && !b0.out_valid) cnt++;
    end
    chk("mul_busy_cycles", cnt, 64);
    chk("mul_flags_during", flags(), 4'b0100);
    @(negedge clk);
    chk("mul_valid", b0.out_valid, 1);
    chk("mul_busy_done", b0.busy, 0);
    chk("mul_result", b0.result, 64'h3_0000_0003);
    b0.A = 64'd9; b0.B = 64'd9; b0.cntrl = 3'b010; b0.in_valid = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b0.out_valid && !b0.in_ready && b0.result == 64'h3_0000_0003 && b0.busy == 0) cnt++;
    end
    chk("stall_stable", cnt, 5);
    chk("stall_flags", flags(), 4'b0100);
    b0.in_valid = 0;
    b0.out_ready = 1;
    drain();
    chk("mul_flags", flags(), 4'b0000);
    chk("mul_idle", b0.out_valid, 0);
    @(negedge clk);
    b1.A = 8'hFF; b1.B = 8'hFF; b1.cntrl = 3'b111; b1.in_valid = 1;
    @(posedge clk);
    #1 b1.in_valid = 0;
    @(negedge clk);
    chk("m8_busy1", {b1.busy, b1.out_valid}, 2'b10);
    @(negedge clk);
    chk("m8_busy2", {b1.busy, b1.out_valid}, 2'b10);
    @(negedge clk);
    chk("m8_valid", {b1.busy, b1.out_valid}, 2'b01);
    chk("m8_result", b1.result, 8'h01);
    @(negedge clk);
    send(64'd5, 64'd5, 3'b011, 1);
    drain();
    chk("pre_rst_flags", flags(), 4'b0101);
    @(negedge clk);
    b0.A = 64'd5; b0.B = 64'd7; b0.cntrl = 3'b111; b0.set_flags = 1; b0.in_valid = 1;
    @(posedge clk);
    #1 b0.in_valid = 0;
    repeat (9) @(posedge clk);
    chk("pre_rst_busy", b0.busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mul_valid", b0.out_valid, 0);
    chk("rst_mul_busy", b0.busy, 0);
    chk("rst_mul_flags", flags(), 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    send(64'd1, 64'd1, 3'b010, 0);
    chk("post_rst_result", b0.result, 64'd2);
    chk("post_rst_valid", b0.out_valid, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
